// File: rtl/render_param_pkg.sv
// Shared types and constants for the render parameter shadow bank.
package render_param_pkg;

  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned STATUS_W    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } commit_state_e;

  // Status word layout: {15'b0, pending, frame_count}
  function automatic logic [STATUS_W-1:0] status_word(
    input logic                   pending,
    input logic [FRAME_CNT_W-1:0] frame_count
  );
    return {15'b0, pending, frame_count};
  endfunction

endpackage

// File: rtl/param_commit_ctrl.sv
// Commit controller: arms on a commit, copies shadow to active on the next
// frame_start, and tracks completed copies in frame_count.
module param_commit_ctrl
  import render_param_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   commit,
  input  logic                   frame_start,
  output logic                   copy_c,
  output logic                   pending,
  output logic                   update_pulse,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  commit_state_e state_q;
  commit_state_e state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A commit arriving with the copying frame_start re-arms for the next frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit) state_d = PEND;
      PEND:    if (frame_start && !commit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending = 1'b0;
    copy_c  = 1'b0;
    if (state_q == PEND) begin
      pending = 1'b1;
      copy_c  = frame_start;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      update_pulse <= 1'b0;
      frame_count  <= '0;
    end else begin
      update_pulse <= copy_c;
      if (copy_c) frame_count <= frame_count + FRAME_CNT_W'(1);
    end
  end

endmodule

// File: rtl/param_shadow_bank.sv
// Double-buffered render parameter bank: host writes land in shadow registers
// and are copied to the active bank at vblank. Readback: PARAM_SHADOW_READBACK_EN.
module param_shadow_bank
  import render_param_pkg::*;
#(
  parameter int unsigned NUM_REGS = 17,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          avs_address,
  input  logic                       avs_write,
  input  logic [DATA_W-1:0]          avs_writedata,
  input  logic                       avs_read,
  output logic [DATA_W-1:0]          avs_readdata,
  input  logic                       frame_start,
  output logic [NUM_REGS*DATA_W-1:0] param_out,
  output logic                       update_pulse,
  output logic                       pending
);

  logic [DATA_W-1:0]      shadow [NUM_REGS];
  logic [DATA_W-1:0]      active [NUM_REGS];
  logic                   commit_c;
  logic                   copy_c;
  logic [FRAME_CNT_W-1:0] frame_count;

  assign commit_c = avs_write && (avs_address == ADDR_W'(NUM_REGS));

  param_commit_ctrl u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .commit       (commit_c),
    .frame_start  (frame_start),
    .copy_c       (copy_c),
    .pending      (pending),
    .update_pulse (update_pulse),
    .frame_count  (frame_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) shadow[i] <= '0;
    end else if (avs_write) begin
      for (int i = 0; i < int'(NUM_REGS); i++)
        if (avs_address == ADDR_W'(i)) shadow[i] <= avs_writedata;
    end
  end

  // Copy samples pre-edge shadow, so a coincident host write stays shadow-only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) active[i] <= '0;
    end else if (copy_c) begin
      for (int i = 0; i < int'(NUM_REGS); i++) active[i] <= shadow[i];
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_out
    assign param_out[g*DATA_W +: DATA_W] = active[g];
  end

`ifdef PARAM_SHADOW_READBACK_EN
  logic [DATA_W-1:0] rd_mux_c;

  always_comb begin
    rd_mux_c = '0;
    if (avs_address == ADDR_W'(NUM_REGS))
      rd_mux_c = DATA_W'(status_word(pending, frame_count));
    for (int i = 0; i < int'(NUM_REGS); i++)
      if (avs_address == ADDR_W'(i)) rd_mux_c = shadow[i];
  end

  always_ff @(posedge clk) begin
    if (reset)         avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux_c;
  end
`else
  logic unused_rd;
  assign unused_rd    = ^{avs_read, frame_count};
  assign avs_readdata = '0;
`endif

endmodule

// File: tb/tb_param_shadow_bank.sv
// Self-checking bench for param_shadow_bank: directed scenarios plus random
// traffic against a per-cycle rule model of the shadow/active banks.
module tb_param_shadow_bank;

  localparam int unsigned NUM_REGS = 17;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS + 1);
  localparam int unsigned PW       = NUM_REGS * DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] avs_address = '0;
  logic              avs_write = 1'b0;
  logic [DATA_W-1:0] avs_writedata = '0;
  logic              avs_read = 1'b0;
  logic [DATA_W-1:0] avs_readdata;
  logic              frame_start = 1'b0;
  logic [PW-1:0]     param_out;
  logic              update_pulse;
  logic              pending;

  param_shadow_bank #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .frame_start   (frame_start),
    .param_out     (param_out),
    .update_pulse  (update_pulse),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] shadow_m [NUM_REGS];
  logic [DATA_W-1:0] active_m [NUM_REGS];
  logic              pend_m = 1'b0;
  logic [15:0]       fc_m   = '0;
  logic              pulse_m = 1'b0;
  logic [DATA_W-1:0] rd_m   = '0;
  int                pulses_seen = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bank(input string tag, input logic [PW-1:0] exp);
    checks++;
    assert (param_out === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, param_out, exp);
    end
  endtask

  function automatic logic [PW-1:0] bank_m();
    logic [PW-1:0] v;
    for (int i = 0; i < int'(NUM_REGS); i++) v[i*DATA_W +: DATA_W] = active_m[i];
    return v;
  endfunction

  // One clock of stimulus; model advances by the block's rules, then outputs are compared.
  task automatic step(input logic rst, input logic wr, input int addr,
                      input logic [DATA_W-1:0] data, input logic rd, input logic fs);
    logic commit, copy;
    reset = rst; avs_write = wr; avs_address = ADDR_W'(addr);
    avs_writedata = data; avs_read = rd; frame_start = fs;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin shadow_m[i] = '0; active_m[i] = '0; end
      pend_m = 1'b0; fc_m = '0; pulse_m = 1'b0; rd_m = '0;
    end else begin
      commit = wr && (addr == int'(NUM_REGS));
      copy   = fs && pend_m;
`ifdef PARAM_SHADOW_READBACK_EN
      if (rd) begin
        if (addr < int'(NUM_REGS))       rd_m = shadow_m[addr];
        else if (addr == int'(NUM_REGS)) rd_m = {15'b0, pend_m, fc_m};
        else                             rd_m = '0;
      end
`endif
      if (copy) active_m = shadow_m;
      if (wr && addr < int'(NUM_REGS)) shadow_m[addr] = data;
      if (commit)    pend_m = 1'b1;
      else if (copy) pend_m = 1'b0;
      if (copy) fc_m = fc_m + 16'd1;
      pulse_m = copy;
    end
    #1;
    if (update_pulse === 1'b1) pulses_seen++;
    chk_bank("param_out", bank_m());
    chk("update_pulse", DATA_W'(update_pulse), DATA_W'(pulse_m));
    chk("pending", DATA_W'(pending), DATA_W'(pend_m));
    chk("avs_readdata", avs_readdata, rd_m);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    int p0;
    logic [DATA_W-1:0] exp_rd;

    // Reset state
    step(1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
    chk_bank("reset_param_out", '0);
    chk("reset_pending", DATA_W'(pending), '0);

    // Shadow write without commit: frame_start never copies
    step(1'b0, 1'b1, 0, 32'h0001_0000, 1'b0, 1'b0);
    p0 = pulses_seen;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
    end
    chk("nocommit_active0", param_out[0 +: DATA_W], '0);
    chk("nocommit_pulses", DATA_W'(pulses_seen - p0), '0);

    // Write, commit, frame_start
    step(1'b0, 1'b1, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b0, 1'b1, NUM_REGS, 32'h1234_5678, 1'b0, 1'b0);
    chk("commit_pending", DATA_W'(pending), 32'd1);
    step(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    chk("copy_active3", param_out[3*DATA_W +: DATA_W], 32'hDEAD_BEEF);
    chk("copy_pulse", DATA_W'(update_pulse), 32'd1);
    chk("copy_pending", DATA_W'(pending), '0);
    step(1'b0, 1'b0, NUM_REGS, '0, 1'b1, 1'b0);
    chk("pulse_one_cycle", DATA_W'(update_pulse), '0);
`ifdef PARAM_SHADOW_READBACK_EN
    chk("status_after_copy", avs_readdata, 32'h0000_0001);
`else
    chk("readdata_const", avs_readdata, '0);
`endif

    // Shadow write coinciding with the copy stays shadow-only
    step(1'b0, 1'b1, NUM_REGS, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5, 32'h0000_0005, 1'b0, 1'b1);
    chk("coinc_active5_old", param_out[5*DATA_W +: DATA_W], '0);
    step(1'b0, 1'b0, 5, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, NUM_REGS, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    chk("coinc_active5_new", param_out[5*DATA_W +: DATA_W], 32'h0000_0005);

    // Commit with frame_start in IDLE: arm only, next frame_start copies
    step(1'b0, 1'b1, 7, 32'hCAFE_0007, 1'b0, 1'b0);
    p0 = pulses_seen;
    step(1'b0, 1'b1, NUM_REGS, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
    chk("idle_both_pending", DATA_W'(pending), 32'd1);
    chk("idle_both_nocopy", param_out[7*DATA_W +: DATA_W], '0);
    chk("idle_both_pulses", DATA_W'(pulses_seen - p0), '0);
    step(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    chk("idle_both_copy", param_out[7*DATA_W +: DATA_W], 32'hCAFE_0007);

    // Random traffic over all addresses including commit and out-of-range
    for (int k = 0; k < 400; k++)
      step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, NUM_REGS + 2)),
           $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));

    // frame_count wrap: commit+frame_start every cycle copies each cycle while staying armed
    step(1'b0, 1'b1, NUM_REGS, '0, 1'b0, 1'b0);
    n = 65536 - int'(fc_m);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, NUM_REGS, $urandom, 1'b0, 1'b1);
    step(1'b0, 1'b0, NUM_REGS, '0, 1'b1, 1'b0);
`ifdef PARAM_SHADOW_READBACK_EN
    exp_rd = 32'h0001_0000;
`else
    exp_rd = '0;
`endif
    chk("wrap_status", avs_readdata, exp_rd);
    step(1'b0, 1'b0, NUM_REGS + 1, '0, 1'b1, 1'b0);
    chk("read_above_status", avs_readdata, '0);

    // Reset while pending discards everything
    step(1'b0, 1'b1, 2, 32'h0BAD_F00D, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, NUM_REGS, '0, 1'b0, 1'b0);
    chk("pre_reset_pending", DATA_W'(pending), 32'd1);
    step(1'b1, 1'b1, NUM_REGS, '0, 1'b1, 1'b1);
    chk_bank("post_reset_param_out", '0);
    chk("post_reset_pending", DATA_W'(pending), '0);
    chk("post_reset_pulse", DATA_W'(update_pulse), '0);
    chk("post_reset_readdata", avs_readdata, '0);
    step(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    chk("post_reset_no_copy", DATA_W'(update_pulse), '0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_shadow_bank.md
PARAM_SHADOW_BANK -- requirements
Module: param_shadow_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 17, giving the number of 32-bit render parameters (eye xyz, 3x3 lookat, four shifts, enables).
REQ-002 SHALL have parameter DATA_W, default 32, giving the width of each parameter register.
REQ-003 SHALL have parameter ADDR_W, default $clog2(NUM_REGS+1), giving the word-address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port avs_address, input, ADDR_W bits: word address.
REQ-007 SHALL have port avs_write, input, 1 bit: write strobe.
REQ-008 SHALL have port avs_writedata, input, DATA_W bits: write data.
REQ-009 SHALL have port avs_read, input, 1 bit: read strobe.
REQ-010 SHALL have port avs_readdata, output, DATA_W bits: read data, 1-cycle latency.
REQ-011 SHALL have port frame_start, input, 1 bit: single-cycle pulse at the start of vertical blank.
REQ-012 SHALL have port param_out, output, NUM_REGS*DATA_W bits: active bank, register i at bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port update_pulse, output, 1 bit: high for one cycle after each active-bank copy.
REQ-014 SHALL have port pending, output, 1 bit: a commit is waiting for frame_start.

Function
REQ-015 SHALL write avs_writedata into shadow[i] on avs_write when avs_address = i < NUM_REGS; the active bank is unchanged.
REQ-016 SHALL treat avs_write at avs_address = NUM_REGS as a commit and ignore its data; writes to addresses above NUM_REGS SHALL be ignored.
REQ-017 SHALL implement a commit FSM with states IDLE and PEND; pending = (state == PEND).
REQ-018 SHALL transition IDLE->PEND on a commit; in IDLE, frame_start SHALL do nothing.
REQ-019 SHALL, on frame_start in PEND, copy all shadow registers to the active bank in one cycle and go to IDLE.
REQ-020 SHALL keep the FSM in PEND on a commit while in PEND (commits coalesce).
REQ-021 SHALL keep the FSM in PEND after the copy when a commit and frame_start occur together in PEND.
REQ-022 SHALL move IDLE->PEND with no copy when a commit and frame_start occur together in IDLE.
REQ-023 SHALL copy the pre-write shadow value when a shadow write and the copy hit the same cycle; the new value stays in shadow only.
REQ-024 SHALL assert update_pulse in the cycle after the copy edge, for exactly one cycle.
REQ-025 SHALL keep a 16-bit frame_count that increments on every copy and wraps 0xFFFF->0x0000.
REQ-026 SHALL drive param_out from active-bank registers only, never combinationally from shadow.

Reset
REQ-027 SHALL, on reset, clear all shadow and active registers to 0, set FSM to IDLE, frame_count to 0, and update_pulse, pending and avs_readdata to 0.
REQ-028 SHALL let reset override a coincident write, commit or frame_start; a pending commit is discarded.

Configuration
REQ-029 SHALL, with PARAM_SHADOW_READBACK_EN defined, register avs_readdata one cycle after avs_read.
REQ-030 SHALL return shadow[i] for addr < NUM_REGS, {15'b0, pending, frame_count} for addr = NUM_REGS, and 0 otherwise.
REQ-031 SHALL, with PARAM_SHADOW_READBACK_EN undefined, hold avs_readdata at constant 0 and generate no read mux logic.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, PEND) and the frame_count width constant (16) in shared package render_param_pkg.
REQ-033 SHALL place the FSM, frame_count and update_pulse in sub-module param_commit_ctrl; the register arrays stay in the top level.

Verification
REQ-034 SHALL cover: write shadow[0]=0x00010000 with no commit, then 3 frame_starts -> param_out[31:0] stays 0 and update_pulse never fires.
REQ-035 SHALL cover: write shadow[3]=0xDEADBEEF, commit, then frame_start -> active[3]=0xDEADBEEF one edge later, update_pulse 1 cycle, pending 1->0, frame_count=1.
REQ-036 SHALL cover: in PEND, a shadow[5]=0x5 write in the same cycle as frame_start -> active[5] keeps its old value and shadow[5]=0x5; a commit plus the next frame_start -> active[5]=0x5.
REQ-037 SHALL cover: a commit and frame_start together in IDLE -> no copy and pending=1; the next frame_start copies.
REQ-038 SHALL cover: 65536 commit/frame_start pairs -> frame_count wraps to 0; reset asserted while pending -> all outputs 0 and pending=0.
REQ-039 SHALL cover, with READBACK_EN: a read of addr NUM_REGS after a commit returns 0x00010000|frame_count one cycle later, and a read of addr NUM_REGS+1 returns 0.
